// File: rtl/axi_coeff2data.sv
// Read-back responder for the 2D FIR coefficient bank: coefficients, status, checksum and ID
// through a fixed two-stage read pipeline, plus a 25-cycle coefficient checksum sweep.
module axi_coeff2data #(
   parameter logic [31:0] ID_VALUE = 32'h2DF1_0001
) (
   input  logic               microblaze_clk,
   input  logic               rst,
   input  logic [7:0]         rd_addr,
   input  logic               rd_en,
   output logic [31:0]        rd_data,
   output logic               rd_valid,
   input  logic signed [15:0] coeff00, coeff01, coeff02, coeff03, coeff04,
   input  logic signed [15:0] coeff10, coeff11, coeff12, coeff13, coeff14,
   input  logic signed [15:0] coeff20, coeff21, coeff22, coeff23, coeff24,
   input  logic signed [15:0] coeff30, coeff31, coeff32, coeff33, coeff34,
   input  logic signed [15:0] coeff40, coeff41, coeff42, coeff43, coeff44,
   input  logic               frame_done,
   input  logic               overflow,
   input  logic               csum_start
);

   typedef enum logic {IDLE, ACCUM} csumState_e;

   logic signed [15:0] coeffs [25];

   logic              s1Valid_q;
   logic [5:0]        s1Idx_q;
   logic [31:0]       rdData_q, readWord;
   logic              rdValid_q;
   logic [15:0]       frameCnt_q;
   logic              ovfSticky_q, ovfSticky_d;
   csumState_e        state_q, state_d;
   logic [4:0]        idx_q, idx_d;
   logic [20:0]       acc_q, acc_d;
   logic [20:0]       checksum_q, checksum_d;
   logic              csumValid_q, csumValid_d;
   logic              csumBusy;
   logic [20:0]       term;

   assign coeffs = '{coeff00, coeff01, coeff02, coeff03, coeff04,
                     coeff10, coeff11, coeff12, coeff13, coeff14,
                     coeff20, coeff21, coeff22, coeff23, coeff24,
                     coeff30, coeff31, coeff32, coeff33, coeff34,
                     coeff40, coeff41, coeff42, coeff43, coeff44};

   assign csumBusy = (state_q == ACCUM);
   assign rd_data  = rdData_q;
   assign rd_valid = rdValid_q;

   // Register content is taken from the stage-2 cycle, so the mux decodes the stage-1 index.
   always_comb begin
      readWord = 32'd0;
      if (s1Idx_q < 6'd25) begin
         readWord = {{16{coeffs[s1Idx_q[4:0]][15]}}, coeffs[s1Idx_q[4:0]]};
      end else begin
         case (s1Idx_q)
            6'd25:   readWord = {frameCnt_q, 13'd0, ovfSticky_q, csumValid_q, csumBusy};
            6'd26:   readWord = {{11{checksum_q[20]}}, checksum_q};
            6'd27:   readWord = ID_VALUE;
            default: readWord = 32'd0;
         endcase
      end
   end

   // A pending STATUS read clears the sticky bit on the edge that loads rd_data; a new overflow wins.
   always_comb begin
      ovfSticky_d = ovfSticky_q;
      if (s1Valid_q && (s1Idx_q == 6'd25)) begin
         ovfSticky_d = 1'b0;
      end
      if (overflow) begin
         ovfSticky_d = 1'b1;
      end
   end

   always_ff @(posedge microblaze_clk) begin
      if (rst) begin
         s1Valid_q   <= 1'b0;
         s1Idx_q     <= 6'd0;
         rdData_q    <= 32'd0;
         rdValid_q   <= 1'b0;
         frameCnt_q  <= 16'd0;
         ovfSticky_q <= 1'b0;
      end else begin
         s1Valid_q   <= rd_en;
         s1Idx_q     <= rd_addr[7:2];
         rdValid_q   <= s1Valid_q;
         if (s1Valid_q) begin
            rdData_q <= readWord;
         end
         if (frame_done) begin
            frameCnt_q <= frameCnt_q + 16'd1;
         end
         ovfSticky_q <= ovfSticky_d;
      end
   end

   always_ff @(posedge microblaze_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= 5'd0;
         acc_q       <= 21'd0;
         checksum_q  <= 21'd0;
         csumValid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         checksum_q  <= checksum_d;
         csumValid_q <= csumValid_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (csum_start) state_d = ACCUM;
         ACCUM:   if (idx_q == 5'd24) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Coefficients are sampled live during the sweep; 25 terms of 16 bits cannot overflow 21 bits.
   always_comb begin
      term        = {{5{coeffs[idx_q][15]}}, coeffs[idx_q]};
      idx_d       = idx_q;
      acc_d       = acc_q;
      checksum_d  = checksum_q;
      csumValid_d = csumValid_q;
      case (state_q)
         IDLE: begin
            if (csum_start) begin
               idx_d       = 5'd0;
               acc_d       = 21'd0;
               csumValid_d = 1'b0;
            end
         end
         ACCUM: begin
            acc_d = acc_q + term;
            idx_d = idx_q + 5'd1;
            if (idx_q == 5'd24) begin
               checksum_d  = acc_q + term;
               csumValid_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: doc/axi_coeff2data.md
# axi_coeff2data

Register read-back responder for the 2D FIR coefficient bank. It sits on the MicroBlaze clock domain beside the coefficient write block and receives the 25 live coefficients. It returns coefficients, filter status and a coefficient checksum to the AXI slave read channel through a fixed 2-cycle pipelined read port. A 25-cycle checksum state machine lets firmware confirm that a coefficient download landed intact.

## Interface
- ID_VALUE, 32'h2DF1_0001, constant returned at ID register.
- microblaze_clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; synchronous, active-high.
- rd_addr  in  8  byte address; rd_addr[1:0] ignored, word index = rd_addr[7:2].
- rd_en  in  1  read strobe, one read per cycle it is high.
- rd_data  out  32  read data.
- rd_valid  out  1  one-cycle pulse marking rd_data valid.
- coeff00..coeff44  in  16 each, signed  live coefficients; index k = 5*row+col (coeff00=k0, coeff44=k24).
- frame_done  in  1  pulse per filtered output frame.
- overflow  in  1  pulse on filter output saturation.
- csum_start  in  1  pulse starting a checksum sweep.

## Operation
- Register map, word index from rd_addr[7:2]:
  - 0–24 (0x00–0x60): coefficient k, sign-extended to 32 bits.
  - 25 (0x64) STATUS: bit0 csum_busy, bit1 csum_valid, bit2 ovf_sticky, bits15:3 zero, bits31:16 frame_cnt.
  - 26 (0x68) CHECKSUM: 21-bit signed sum, sign-extended to 32 bits.
  - 27 (0x6C) ID: ID_VALUE.
  - 28–63: read as 0.
- frame_cnt: 16-bit counter, +1 per frame_done, wraps 0xFFFF→0x0000. Cleared only by rst.
- ovf_sticky: set by overflow. Cleared by a STATUS read at the pipeline stage-2 edge, i.e. the edge that loads rd_data. If overflow and that clearing edge coincide, set wins and the bit stays 1.
- Checksum FSM, states IDLE and ACCUM:
  - IDLE + csum_start: idx←0, acc←0, csum_busy←1, csum_valid←0, go to ACCUM.
  - ACCUM: acc←acc+sext21(coeff[idx]) and idx←idx+1 each cycle.
  - ACCUM with idx==24: adds the final term, then checksum←final sum, csum_valid←1, csum_busy←0, go to IDLE.
  - csum_start while in ACCUM is ignored.
  - Coefficients are sampled live. A change during the sweep is taken as-is.
- Width: 25×(±32768) fits in a 21-bit signed value, so there is no overflow handling.

## Timing
- Read pipeline:
  - rd_en and rd_addr sampled at edge N (stage 1: address/decode registered).
  - Stage 2 registers the muxed data at edge N+1.
  - rd_data and rd_valid are visible in the cycle after edge N+1. Latency is 2 cycles.
- Back-to-back reads run at one per cycle with no bubbles. Order is preserved.
- With no read, rd_valid=0 and rd_data holds its last value.
- Register content is the value present in the stage-2 cycle.
- Checksum timing:
  - csum_start sampled at edge S.
  - csum_busy=1 from S+1; 25 ACCUM cycles.
  - checksum valid, csum_valid=1 and csum_busy=0 from S+26.
  - A new start is accepted at S+26.
- Reset values: rd_data=0, rd_valid=0, frame_cnt=0, ovf_sticky=0, csum_busy=0, csum_valid=0, checksum=0, FSM=IDLE, pipeline empty.
- rst during ACCUM aborts the sweep: FSM to IDLE, flags cleared.
- rst during a pending read: that read produces no rd_valid.

## Test plan
- Coefficient read-back: coeff k = k−12 (k0=−12 … k24=+12). Read 0x00, 0x30, 0x60 back-to-back → 0xFFFFFFF4, 0x00000000, 0x0000000C on three consecutive rd_valid pulses, 2 cycles after each rd_en.
- Checksum sweep: all coeffs 0x7FFF, pulse csum_start → busy for 25 cycles, then CHECKSUM=0x000C7FE7 (819175) and STATUS[1:0]=2'b10. Then all coeffs 0x8000 and a new sweep → 0xFFF38000.
- Start while busy: second csum_start at S+10 → ignored, completion still at S+26.
- Sticky overflow: overflow pulse, then STATUS read → bit2=1; next read → bit2=0. Overflow on the clearing edge → next read bit2=1.
- Frame counter: 65537 frame_done pulses → STATUS[31:16]=0x0001. ID read → 0x2DF10001. Read 0x80 → 0.
- Reset mid-sweep: rst at S+12 → busy=0, valid=0, checksum=0, and no rd_valid for a read issued in the rst cycle.
